lcd_rx: RTL and testbench

Receive-side decoder for the serial-RGB LCD bus driven by the panel timing generator. Samples the 8-bit byte stream plus `lcd_hsync`/`lcd_vsync`/`lcd_den` on the same pixel clock and reassembles R,G,B byte triplets into 24-bit pixels tagged with (x, y). Used in loopback self-test and in the capture path that feeds frame checksums. Detects malformed lines and frames.

---
 rtl/lcd_rx.sv | 194 +++++++++++++++++++
 tb/tb_lcd_rx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rx.sv
// Serial-RGB LCD receive decoder: rebuilds {R,G,B} pixels tagged with (x, y)
// from the byte stream and flags malformed lines and frames.
module lcd_rx #(
  parameter int H_VISIBLE = 320,
  parameter int V_VISIBLE = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  lcd_dat,
  input  logic        lcd_hsync,
  input  logic        lcd_vsync,
  input  logic        lcd_den,
  output logic        pixel_valid,
  output logic [23:0] rgb,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic        synced,
  output logic        frame_start,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [9:0] H_CNT = 10'(H_VISIBLE);
  localparam logic [8:0] V_CNT = 9'(V_VISIBLE);

  typedef enum logic [2:0] {
    S_UNSYNC,
    S_IDLE,
    S_PH_R,
    S_PH_G,
    S_PH_B,
    S_OVER
  } state_e;

  state_e      state_q, state_d;
  logic        vsync_q;
  logic        den_q;
  logic [9:0]  col_q, col_d;
  logic [8:0]  line_q, line_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  g_q, g_d;
  logic        ovf_q, ovf_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [23:0] rgb_q, rgb_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        synced_q, synced_d;
  logic        frame_start_q, frame_start_d;
  logic        line_err_q, line_err_d;
  logic        frame_err_q, frame_err_d;

  logic        vsync_fall;
  logic        den_fall;
  logic        den_rise;
  logic        line_active;
  logic [8:0]  line_inc;

  assign vsync_fall  = vsync_q && !lcd_vsync;
  assign den_fall    = den_q && !lcd_den;
  assign den_rise    = !den_q && lcd_den;
  assign line_active = (state_q == S_PH_R) || (state_q == S_PH_G) ||
                       (state_q == S_PH_B) || (state_q == S_OVER);
  assign line_inc    = (line_q < V_CNT) ? line_q + 9'd1 : line_q;

  // NOTE: every signal is given its default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    line_d        = line_q;
    r_d           = r_q;
    g_d           = g_q;
    ovf_d         = ovf_q;
    pixel_valid_d = 1'b0;
    rgb_d         = rgb_q;
    x_d           = x_q;
    y_d           = y_q;
    synced_d      = synced_q;
    frame_start_d = 1'b0;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;

    if (vsync_fall) begin
      // A frame that overflowed its line budget is wrong even though the
      // saturated line counter reads exactly V_VISIBLE.
      state_d       = S_IDLE;
      synced_d      = 1'b1;
      frame_start_d = 1'b1;
      line_d        = '0;
      ovf_d         = 1'b0;
      frame_err_d   = synced_q && ((line_q != V_CNT) || ovf_q);
    end else if (line_active && !lcd_hsync) begin
      state_d    = S_IDLE;
      line_err_d = 1'b1;
      line_d     = line_inc;
    end else if (line_active && den_rise) begin
      state_d    = S_IDLE;
      line_d     = line_inc;
      line_err_d = (state_q == S_PH_G) || (state_q == S_PH_B) ||
                   (state_q == S_OVER) || (col_q != H_CNT);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Lines start on the den fall, so a line aborted by hsync is not
          // restarted by its trailing bytes.
          if (den_fall) begin
            if (line_q == V_CNT) begin
              state_d     = S_OVER;
              frame_err_d = 1'b1;
              ovf_d       = 1'b1;
            end else begin
              r_d     = lcd_dat;
              col_d   = '0;
              state_d = S_PH_G;
            end
          end
        end
        S_PH_R: begin
          if (!lcd_den) begin
            r_d     = lcd_dat;
            state_d = S_PH_G;
          end
        end
        S_PH_G: begin
          g_d     = lcd_dat;
          state_d = S_PH_B;
        end
        S_PH_B: begin
          if (col_q == H_CNT) begin
            state_d = S_OVER;
          end else begin
            pixel_valid_d = 1'b1;
            rgb_d         = {r_q, g_q, lcd_dat};
            x_d           = col_q[8:0];
            y_d           = line_q[7:0];
            col_d         = col_q + 10'd1;
            state_d       = S_PH_R;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_UNSYNC;
      vsync_q       <= 1'b1;
      den_q         <= 1'b1;
      col_q         <= '0;
      line_q        <= '0;
      r_q           <= '0;
      g_q           <= '0;
      ovf_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      rgb_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      synced_q      <= 1'b0;
      frame_start_q <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= lcd_vsync;
      den_q         <= lcd_den;
      col_q         <= col_d;
      line_q        <= line_d;
      r_q           <= r_d;
      g_q           <= g_d;
      ovf_q         <= ovf_d;
      pixel_valid_q <= pixel_valid_d;
      rgb_q         <= rgb_d;
      x_q           <= x_d;
      y_q           <= y_d;
      synced_q      <= synced_d;
      frame_start_q <= frame_start_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign rgb         = rgb_q;
  assign x           = x_q;
  assign y           = y_q;
  assign synced      = synced_q;
  assign frame_start = frame_start_q;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_lcd_rx.sv
// Self-checking bench for lcd_rx: directed frame/line scenarios with random
// pixel data, compared against a line-level reference model.
module tb_lcd_rx;

  localparam int H = 16;
  localparam int V = 8;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [23:0] rgb;
    logic [8:0]  x;
    logic [7:0]  y;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  lcd_dat;
  logic        lcd_hsync;
  logic        lcd_vsync;
  logic        lcd_den;
  logic        pixel_valid;
  logic [23:0] rgb;
  logic [8:0]  x;
  logic [7:0]  y;
  logic        synced;
  logic        frame_start;
  logic        line_err;
  logic        frame_err;

  lcd_rx #(.H_VISIBLE(H), .V_VISIBLE(V)) dut (
    .clk        (clk),
    .reset      (reset),
    .lcd_dat    (lcd_dat),
    .lcd_hsync  (lcd_hsync),
    .lcd_vsync  (lcd_vsync),
    .lcd_den    (lcd_den),
    .pixel_valid(pixel_valid),
    .rgb        (rgb),
    .x          (x),
    .y          (y),
    .synced     (synced),
    .frame_start(frame_start),
    .line_err   (line_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, sampled on the falling edge.
  pix_t obs_pix[$];
  int   obs_cyc[$];
  int   n_le = 0;
  int   n_fe = 0;
  int   n_fs = 0;

  always @(negedge clk) begin
    if (pixel_valid) begin
      obs_pix.push_back(pix_t'{rgb, x, y});
      obs_cyc.push_back(cyc);
    end
    if (line_err)    n_le++;
    if (frame_err)   n_fe++;
    if (frame_start) n_fs++;
  end

  // Reference model: frame/line bookkeeping kept as plain counters.
  int   m_line   = 0;
  bit   m_synced = 1'b0;
  bit   m_ovf    = 1'b0;
  pix_t exp_pix[$];
  int   exp_le;
  int   exp_fe;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic hs, input logic vs, input logic de);
    lcd_dat   = d;
    lcd_hsync = hs;
    lcd_vsync = vs;
    lcd_den   = de;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic clear_obs();
    obs_pix.delete();
    obs_cyc.delete();
    n_le = 0;
    n_fe = 0;
    n_fs = 0;
  endtask

  task automatic make_pattern(input int yy, input int npix, output byte_q_t b);
    b = {};
    for (int i = 0; i < npix; i++) begin
      b.push_back(8'(i));
      b.push_back(8'(yy));
      b.push_back(8'hA5);
    end
  endtask

  task automatic make_random(input int nbytes, output byte_q_t b);
    b = {};
    for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom_range(0, 255)));
  endtask

  // Expected outcome of one line: pixels grouped from byte triplets, capped at
  // H, truncated at an hsync abort; anything past V lines is an overflow.
  task automatic model_line(input byte_q_t b, input int abort_at);
    int lim;
    int np;
    exp_pix.delete();
    exp_le = 0;
    exp_fe = 0;
    if (!m_synced) return;
    if (m_line >= V) begin
      exp_le = 1;
      exp_fe = 1;
      m_ovf  = 1'b1;
    end else begin
      lim = (abort_at >= 0) ? abort_at : b.size();
      np  = lim / 3;
      if (np > H) np = H;
      for (int i = 0; i < np; i++)
        exp_pix.push_back(pix_t'{{b[3*i], b[3*i+1], b[3*i+2]}, 9'(i), 8'(m_line)});
      exp_le = ((abort_at >= 0) || (b.size() != 3 * H)) ? 1 : 0;
    end
    if (m_line < V) m_line++;
  endtask

  task automatic model_vsync();
    exp_fe   = (m_synced && ((m_line != V) || m_ovf)) ? 1 : 0;
    m_synced = 1'b1;
    m_line   = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic send_line(input byte_q_t b, input int abort_at, output int p0);
    idle(1);
    repeat (2) drive(8'h00, 1'b0, 1'b1, 1'b1);
    idle(2);
    p0 = cyc;
    for (int i = 0; i < b.size(); i++)
      drive(b[i], (i == abort_at) ? 1'b0 : 1'b1, 1'b1, 1'b0);
    idle(5);
  endtask

  task automatic check_line(input string tag);
    check({tag, " pixel count"}, 64'(obs_pix.size()), 64'(exp_pix.size()));
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++)
      check($sformatf("%s pix%0d", tag, i), 64'(obs_pix[i]), 64'(exp_pix[i]));
    if (exp_pix.size() > 0)
      check({tag, " hold"}, 64'({rgb, x, y}), 64'(exp_pix[exp_pix.size()-1]));
    check({tag, " line_err"},    64'(n_le), 64'(exp_le));
    check({tag, " frame_err"},   64'(n_fe), 64'(exp_fe));
    check({tag, " frame_start"}, 64'(n_fs), 64'(0));
  endtask

  task automatic do_line(input string tag, input byte_q_t b, input int abort_at, output int p0);
    clear_obs();
    model_line(b, abort_at);
    send_line(b, abort_at, p0);
    check_line(tag);
  endtask

  task automatic do_vsync(input string tag);
    clear_obs();
    model_vsync();
    repeat (2) drive(8'h00, 1'b1, 1'b0, 1'b1);
    idle(4);
    check({tag, " frame_start"}, 64'(n_fs), 64'(1));
    check({tag, " frame_err"},   64'(n_fe), 64'(exp_fe));
    check({tag, " synced"},      64'(synced), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pixel_valid"}, 64'(pixel_valid), 64'(0));
    check({tag, " rgb"},         64'(rgb), 64'(0));
    check({tag, " x"},           64'(x), 64'(0));
    check({tag, " y"},           64'(y), 64'(0));
    check({tag, " synced"},      64'(synced), 64'(0));
    check({tag, " strobes"},     64'({frame_start, line_err, frame_err}), 64'(0));
  endtask

  initial begin
    byte_q_t b;
    int      p0;

    reset = 1'b1;
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(2);

    // Pre-sync data is ignored.
    make_random(3 * H, b);
    do_line("presync", b, -1, p0);
    check("presync synced", 64'(synced), 64'(0));

    // Clean frame with the {x, y, A5} pattern.
    do_vsync("vs1");
    for (int ln = 0; ln < V; ln++) begin
      make_pattern(ln, H, b);
      do_line($sformatf("clean y%0d", ln), b, -1, p0);
      if (ln == 0) begin
        if (obs_cyc.size() > 0)
          check("latency", 64'(obs_cyc[0]), 64'(p0 + 3));
        for (int i = 1; i < obs_cyc.size(); i++)
          check($sformatf("cadence %0d", i), 64'(obs_cyc[i] - obs_cyc[i-1]), 64'(3));
      end
    end
    do_vsync("vs2");

    // Random frame with long, short, normal and aborted lines.
    for (int ln = 0; ln < 4; ln++) begin
      make_random(3 * H, b);
      do_line($sformatf("rand y%0d", ln), b, -1, p0);
    end
    make_random(3 * (H + 2), b);
    do_line("long", b, -1, p0);
    make_random(3 * (H - 1) + 2, b);
    do_line("short", b, -1, p0);
    check("short last x", 64'(x), 64'(H - 2));
    make_random(3 * H, b);
    do_line("after short", b, -1, p0);
    check("after short y", 64'(y), 64'(6));
    make_random(3 * H, b);
    do_line("abort", b, 30, p0);
    do_vsync("vs3");

    // Frame with one line too many.
    for (int ln = 0; ln <= V; ln++) begin
      make_random(3 * H, b);
      do_line($sformatf("ovf y%0d", ln), b, -1, p0);
    end
    do_vsync("vs4");

    // Vsync fall coinciding with a den fall: no pixel is started.
    clear_obs();
    model_vsync();
    make_random(3 * H, b);
    drive(b[0], 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < b.size(); i++) drive(b[i], 1'b1, 1'b1, 1'b0);
    idle(5);
    check("vs+den frame_start", 64'(n_fs), 64'(1));
    check("vs+den frame_err",   64'(n_fe), 64'(exp_fe));
    check("vs+den pixels",      64'(obs_pix.size()), 64'(0));
    check("vs+den line_err",    64'(n_le), 64'(0));
    make_random(3 * H, b);
    do_line("post vs+den", b, -1, p0);

    // Reset while in PH_G.
    make_random(3 * H, b);
    idle(2);
    drive(b[0], 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    drive(b[1], 1'b1, 1'b1, 1'b0);
    check_all_zero("midreset");
    reset    = 1'b0;
    m_synced = 1'b0;
    m_line   = 0;
    m_ovf    = 1'b0;
    clear_obs();
    for (int i = 2; i < b.size(); i++) drive(b[i], 1'b1, 1'b1, 1'b0);
    idle(5);
    check("midreset pixels",  64'(obs_pix.size()), 64'(0));
    check("midreset strobes", 64'(n_le + n_fe + n_fs), 64'(0));
    check("midreset synced",  64'(synced), 64'(0));
    do_vsync("vs5");
    make_random(3 * H, b);
    do_line("after reset", b, -1, p0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
